slc3_mem_responder: RTL and testbench
=====================================

// Module: slc3_mem_responder
// PURPOSE
//   Memory-side responder for the SLC-3 CPU bus: answers Mem_OE/Mem_WE requests issued by the control unit
//   from MAR/MDR. Holds an on-chip word RAM with a fixed, parameterised read latency matching the control unit's
//   3-cycle OE windows, and one MMIO location at 0xFFFF (read = switches, write = hex display register).
// PARAMETERS
//   ADDR_W        10   RAM index width; RAM holds 2**ADDR_W 16-bit words at addresses 0 .. 2**ADDR_W-1
//   READ_LATENCY   2   rising edges (OE sampled high) until Data_to_CPU is updated; legal range 1..7
// PORTS
//   Clk            in   1   system clock, all state on rising edge
//   Reset          in   1   asynchronous, active-high reset
//   ADDR           in  16   word address (from MAR)
//   Data_from_CPU  in  16   write data (from MDR)
//   Mem_OE         in   1   read request / output enable, level, held for whole request
//   Mem_WE         in   1   write request, level, held for whole request; priority over Mem_OE
//   SW             in  16   switch inputs, returned on read of 0xFFFF
//   Data_to_CPU    out 16   registered read data
//   Data_valid     out  1   1 while Data_to_CPU holds data of the current read request
//   HEX_out        out 16   MMIO display register (written at 0xFFFF)
//   Busy           out  1   1 whenever FSM is not IDLE
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, cnt=0, Data_to_CPU=0x0000, Data_valid=0, HEX_out=0x0000, Busy=0.
//     RAM contents are not cleared. Reset during RD_WAIT discards the read; a write already committed stays.
//   Address decode: ADDR==0xFFFF -> MMIO; ADDR < 2**ADDR_W -> RAM[ADDR[ADDR_W-1:0]]; else unmapped.
//     Unmapped read returns 0x0000; unmapped write is dropped (no RAM/HEX change).
//   FSM states: IDLE, RD_WAIT, RD_VALID, WR_HOLD.
//   IDLE: Mem_WE=1 at edge -> commit write this edge (ADDR, Data_from_CPU sampled), -> WR_HOLD.
//     else Mem_OE=1 -> latch ADDR into addr_q, cnt<=1; if READ_LATENCY==1 load Data_to_CPU now, -> RD_VALID;
//     otherwise -> RD_WAIT. Both low -> stay.
//   RD_WAIT: Mem_OE=0 -> abort to IDLE, Data_to_CPU unchanged, Data_valid stays 0.
//     else cnt<=cnt+1; when cnt+1==READ_LATENCY load Data_to_CPU from addr_q source, -> RD_VALID.
//     ADDR/SW changes after request start are ignored for RAM; SW is sampled at the loading edge.
//   RD_VALID: Data_valid=1, Data_to_CPU held; Mem_OE=0 -> IDLE (Data_valid drops next cycle, data held).
//   WR_HOLD: exactly one commit per request; stays while Mem_WE=1; Mem_WE=0 -> IDLE. Mem_OE ignored here.
//   Latency: OE raised in cycle 1 -> Data_to_CPU valid from cycle READ_LATENCY+1 (default: cycle 3,
//     i.e. valid in the 3rd OE cycle when the control unit loads MDR).
//   New request starts only from IDLE: requester must drop OE/WE for >=1 cycle between requests; a level held
//     across two logical requests is one request.
//   Simultaneous WE and OE in IDLE -> write only; Data_to_CPU unchanged.
//   Data_valid=1 only in RD_VALID; Busy = (state != IDLE). All outputs registered or decoded from state only.
// TESTING
//   1. Reset asserted mid-cycle, no clock edge -> all outputs 0 immediately; RAM word 0x0005 written earlier still reads back.
//   2. WE 3 cycles, ADDR=0x0010, data=0x1234; then OE 3 cycles ADDR=0x0010 -> Data_to_CPU=0x1234 in 3rd OE cycle, Data_valid=1.
//   3. SW=0xBEEF, OE 3 cycles at 0xFFFF -> Data_to_CPU=0xBEEF; WE at 0xFFFF data=0x00A5 -> HEX_out=0x00A5, RAM untouched.
//   4. OE for 1 cycle only (abort in RD_WAIT) -> Data_to_CPU keeps previous 0x1234, Data_valid never 1, Busy back to 0.
//   5. WE+OE together at 0x0020 data=0x5A5A for 3 cycles -> single commit, Data_to_CPU unchanged; later read = 0x5A5A.
//   6. Unmapped ADDR=0x8000: write 0xFFFF dropped, read -> 0x0000; READ_LATENCY=1 build: data valid in 2nd OE cycle.

Source files
------------

// File: rtl/slc3_mem_responder.sv
// slc3_mem_responder: SLC-3 bus memory responder with word RAM, fixed read latency and MMIO at 0xFFFF
module slc3_mem_responder #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] SW,
  output logic [15:0] Data_to_CPU,
  output logic        Data_valid,
  output logic [15:0] HEX_out,
  output logic        Busy
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_WAIT  = 2'd1;
  localparam logic [1:0] RD_VALID = 2'd2;
  localparam logic [1:0] WR_HOLD  = 2'd3;
  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] mem [2**ADDR_W];
  logic [15:0] rd_addr, rd_data;
  logic        wr_en, load;
  // read source follows the live bus in IDLE (latency-1 load) and the latched request address afterwards
  always_comb begin
    rd_addr = (state == IDLE) ? ADDR : addr_q;
    rd_data = (rd_addr == 16'hFFFF) ? SW :
              (rd_addr[15:ADDR_W] == '0) ? mem[rd_addr[ADDR_W-1:0]] : 16'h0000;
    wr_en   = (state == IDLE) && Mem_WE && !Reset;
    load    = (state == IDLE) ? (Mem_OE && !Mem_WE && READ_LATENCY == 1) :
              (state == RD_WAIT) && Mem_OE && ({1'b0, cnt} + 4'd1 == 4'(READ_LATENCY));
  end
  // RAM is never cleared by reset, so it lives in its own unreset block
  always_ff @(posedge Clk)
    if (wr_en && ADDR[15:ADDR_W] == '0) mem[ADDR[ADDR_W-1:0]] <= Data_from_CPU;
  // request FSM, latency counter, read data and display register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      Data_to_CPU <= '0;
      HEX_out     <= '0;
    end else begin
      if (load) Data_to_CPU <= rd_data;
      if (wr_en && ADDR == 16'hFFFF) HEX_out <= Data_from_CPU;
      case (state)
        IDLE:
          if (Mem_WE) state <= WR_HOLD;
          else if (Mem_OE) begin
            addr_q <= ADDR;
            cnt    <= 3'd1;
            state  <= (READ_LATENCY == 1) ? RD_VALID : RD_WAIT;
          end
        RD_WAIT:
          if (!Mem_OE) state <= IDLE;
          else begin
            cnt <= cnt + 3'd1;
            if (load) state <= RD_VALID;
          end
        RD_VALID: if (!Mem_OE) state <= IDLE;
        WR_HOLD:  if (!Mem_WE) state <= IDLE;
      endcase
    end
  end
  assign Data_valid = (state == RD_VALID);
  assign Busy       = (state != IDLE);
endmodule

// File: tb/tb_slc3_mem_responder.sv
// tb_slc3_mem_responder: directed checks of the SLC-3 memory responder (latency 2 and latency 1 builds)
module tb_slc3_mem_responder;
  logic        Clk, Reset, Mem_OE, Mem_WE;
  logic [15:0] ADDR, Data_from_CPU, SW;
  logic [15:0] Data_to_CPU, HEX_out, Data_to_CPU1, HEX_out1;
  logic        Data_valid, Busy, Data_valid1, Busy1;
  int checks = 0;
  int errors = 0;
  slc3_mem_responder dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .SW(SW), .Data_to_CPU(Data_to_CPU),
    .Data_valid(Data_valid), .HEX_out(HEX_out), .Busy(Busy)
  );
  slc3_mem_responder #(.READ_LATENCY(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .SW(SW), .Data_to_CPU(Data_to_CPU1),
    .Data_valid(Data_valid1), .HEX_out(HEX_out1), .Busy(Busy1)
  );
  initial Clk = 0;
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; Data_from_CPU = d; Mem_WE = 1;
    repeat (3) @(negedge Clk);
    Mem_WE = 0;
    @(negedge Clk);
  endtask
  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    ADDR = a; Mem_OE = 1;
    @(negedge Clk);
    chk({tag, " busy1"}, 16'(Busy), 16'd1);
    chk({tag, " valid1"}, 16'(Data_valid), 16'd0);
    chk({tag, " lat1 valid"}, 16'(Data_valid1), 16'd1);
    chk({tag, " lat1 data"}, Data_to_CPU1, exp);
    @(negedge Clk);
    chk({tag, " valid2"}, 16'(Data_valid), 16'd1);
    chk({tag, " data2"}, Data_to_CPU, exp);
    @(negedge Clk);
    chk({tag, " data3"}, Data_to_CPU, exp);
    Mem_OE = 0;
    @(negedge Clk);
    chk({tag, " valid end"}, 16'(Data_valid), 16'd0);
    chk({tag, " busy end"}, 16'(Busy), 16'd0);
    chk({tag, " data held"}, Data_to_CPU, exp);
  endtask
  initial begin
    Reset = 1; Mem_OE = 0; Mem_WE = 0; ADDR = 0; Data_from_CPU = 0; SW = 0;
    repeat (2) @(negedge Clk);
    chk("rst data", Data_to_CPU, 16'h0000);
    chk("rst hex", HEX_out, 16'h0000);
    chk("rst flags", {14'd0, Data_valid, Busy}, 16'h0000);
    Reset = 0;
    @(negedge Clk);
    wr(16'h0000, 16'h0123);
    wr(16'h03FF, 16'h7777);
    wr(16'h0010, 16'h1234);
    rd("rd 0010", 16'h0010, 16'h1234);
    ADDR = 16'h03FF; Mem_OE = 1;
    @(negedge Clk);
    chk("abort busy", 16'(Busy), 16'd1);
    Mem_OE = 0;
    @(negedge Clk);
    chk("abort data", Data_to_CPU, 16'h1234);
    chk("abort flags", {14'd0, Data_valid, Busy}, 16'h0000);
    ADDR = 16'h0020; Data_from_CPU = 16'h5A5A; Mem_WE = 1; Mem_OE = 1;
    @(negedge Clk);
    chk("weoe busy", 16'(Busy), 16'd1);
    chk("weoe valid", 16'(Data_valid), 16'd0);
    Data_from_CPU = 16'h1111;
    repeat (2) @(negedge Clk);
    chk("weoe data", Data_to_CPU, 16'h1234);
    Mem_WE = 0; Mem_OE = 0;
    @(negedge Clk);
    chk("weoe idle", 16'(Busy), 16'd0);
    rd("rd 0020", 16'h0020, 16'h5A5A);
    SW = 16'hBEEF;
    rd("rd sw", 16'hFFFF, 16'hBEEF);
    wr(16'hFFFF, 16'h00A5);
    chk("hex wr", HEX_out, 16'h00A5);
    rd("rd 03ff", 16'h03FF, 16'h7777);
    wr(16'h8000, 16'hFFFF);
    chk("unmapped hex", HEX_out, 16'h00A5);
    rd("rd 8000", 16'h8000, 16'h0000);
    rd("rd 0000", 16'h0000, 16'h0123);
    wr(16'h0005, 16'hCAFE);
    ADDR = 16'h0010; Mem_OE = 1;
    @(negedge Clk);
    chk("pre-rst busy", 16'(Busy), 16'd1);
    #2 Reset = 1; Mem_OE = 0;
    #1;
    chk("async data", Data_to_CPU, 16'h0000);
    chk("async hex", HEX_out, 16'h0000);
    chk("async flags", {14'd0, Data_valid, Busy}, 16'h0000);
    chk("async lat1 data", Data_to_CPU1, 16'h0000);
    chk("async lat1 flags", {14'd0, Data_valid1, Busy1}, 16'h0000);
    #1 Reset = 0;
    @(negedge Clk);
    chk("post-rst busy", 16'(Busy), 16'd0);
    rd("rd 0005", 16'h0005, 16'hCAFE);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
